// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory request FSM feeding
// a 2-entry {pc, instr} buffer toward decode, with redirect flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] pc_out
);

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        DROP
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       req_pc_q, req_pc_d;
    logic [1:0]        count_q, count_d;
    logic              head_q, head_d;
    logic [1:0][31:0]  pc_mem_q, pc_mem_d;
    logic [1:0][31:0]  ins_mem_q, ins_mem_d;
    logic              push;
    logic              pop;
    logic              accept;
    logic              tail;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        count_d    = count_q;
        head_d     = head_q;
        pc_mem_d   = pc_mem_q;
        ins_mem_d  = ins_mem_q;
        push       = 1'b0;

        // Credit check uses only the registered count, never this cycle's pop.
        imem_req_valid = (state_q == ISSUE) && (count_q < 2'd2) && !redirect_valid;
        id_valid       = (count_q != 2'd0) && !redirect_valid;
        pop            = id_valid && id_ready;
        accept         = imem_req_valid && imem_req_ready;

        unique case (state_q)
            ISSUE: begin
                if (accept) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    push    = !redirect_valid;
                    state_d = ISSUE;
                end else if (redirect_valid) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase

        tail = head_q ^ (count_q == 2'd1);
        if (push) begin
            pc_mem_d[tail]  = req_pc_q;
            ins_mem_d[tail] = imem_rsp_data;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~32'h3;
            count_d    = 2'd0;
            head_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ISSUE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            count_q    <= '0;
            head_q     <= 1'b0;
            pc_mem_q   <= '0;
            ins_mem_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            pc_mem_q   <= pc_mem_d;
            ins_mem_q  <= ins_mem_d;
        end
    end

    assign imem_req_addr = fetch_pc_q;
    assign pc_out        = fetch_pc_q;
    assign id_pc         = pc_mem_q[head_q];
    assign id_instr      = ins_mem_q[head_q];

endmodule
